// File: rtl/packet_tx_framer_pkg.sv
// Shared definitions for the packet framer and detector: sample format,
// default framing parameters and the framer state encoding.
package packet_tx_framer_pkg;

    localparam int unsigned SAMPLE_W      = 16;
    localparam int unsigned FRAC          = 12;
    localparam int unsigned DEF_PERIOD    = 16;
    localparam int unsigned DEF_REPS      = 10;
    localparam int unsigned DEF_GUARD_LEN = 32;

    // 0.5 in Q4.12: preamble magnitude bound so detector squares cannot overflow
    localparam logic [SAMPLE_W-1:0] Q_HALF = SAMPLE_W'(1) << (FRAC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_PAYLOAD,
        ST_GUARD
    } state_t;

endpackage

// File: rtl/packet_preamble_rom.sv
// Combinational preamble symbol table: idx -> {re, im}, Q4.12, |x| <= 0.5.
// Beyond 16 entries the base table repeats with the imaginary part sign-flipped.
module packet_preamble_rom
    import packet_tx_framer_pkg::*;
#(
    parameter  int unsigned PERIOD = DEF_PERIOD,
    localparam int unsigned IDX_W  = $clog2(PERIOD)
) (
    input  logic [IDX_W-1:0]    i_idx,
    output logic [SAMPLE_W-1:0] o_re,
    output logic [SAMPLE_W-1:0] o_im
);

    logic [3:0]          w_sel;
    logic                w_flip;
    logic [SAMPLE_W-1:0] w_im;

    assign w_sel = 4'(i_idx);

    generate
        if (IDX_W > 4) begin : g_wide
            assign w_flip = ^i_idx[IDX_W-1:4];
        end else begin : g_narrow
            assign w_flip = 1'b0;
        end
    endgenerate

    always_comb begin
        o_re = '0;
        w_im = '0;
        case (w_sel)
            4'd0:  begin o_re = Q_HALF;   w_im = 16'h0000; end
            4'd1:  begin o_re = 16'h05A8; w_im = 16'h05A8; end
            4'd2:  begin o_re = 16'h0000; w_im = Q_HALF;   end
            4'd3:  begin o_re = 16'hFA58; w_im = 16'h05A8; end
            4'd4:  begin o_re = -Q_HALF;  w_im = 16'h0000; end
            4'd5:  begin o_re = 16'hFA58; w_im = 16'hFA58; end
            4'd6:  begin o_re = 16'h0000; w_im = -Q_HALF;  end
            4'd7:  begin o_re = 16'h05A8; w_im = 16'hFA58; end
            4'd8:  begin o_re = 16'h0400; w_im = 16'h0400; end
            4'd9:  begin o_re = 16'hFC00; w_im = 16'h0400; end
            4'd10: begin o_re = 16'h0400; w_im = 16'hFC00; end
            4'd11: begin o_re = 16'hFC00; w_im = 16'hFC00; end
            4'd12: begin o_re = 16'h0200; w_im = 16'h0600; end
            4'd13: begin o_re = 16'hFE00; w_im = 16'hFA00; end
            4'd14: begin o_re = 16'h0600; w_im = 16'h0200; end
            default: begin o_re = 16'hFA00; w_im = 16'hFE00; end
        endcase
    end

    assign o_im = w_flip ? -w_im : w_im;

endmodule

// File: rtl/packet_tx_framer.sv
// Transmit framer: periodic preamble, then payload pulled from a valid/ready
// source, then a zero guard tail. Output stream is registered, no backpressure.
module packet_tx_framer
    import packet_tx_framer_pkg::*;
#(
    parameter int unsigned PERIOD    = DEF_PERIOD,
    parameter int unsigned REPS      = DEF_REPS,
    parameter int unsigned GUARD_LEN = DEF_GUARD_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [15:0]         payload_length_i,
    input  logic                pl_valid_i,
    input  logic [SAMPLE_W-1:0] pl_r_i,
    input  logic [SAMPLE_W-1:0] pl_i_i,
    output logic                pl_ready_o,
    output logic [SAMPLE_W-1:0] r_o,
    output logic [SAMPLE_W-1:0] i_o,
    output logic                valid_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                underrun_o
);

    localparam int unsigned      IDX_W    = $clog2(PERIOD);
    localparam int unsigned      GRD_W    = $clog2(GUARD_LEN + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PERIOD - 1);
    localparam logic [7:0]       REP_LAST = 8'(REPS - 1);
    localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'(GUARD_LEN - 1);
    localparam logic [GRD_W-1:0] GRD_END  = GRD_W'(GUARD_LEN);

    state_t              r_state;
    state_t              w_next;
    logic [IDX_W-1:0]    r_idx;
    logic [7:0]          r_rep;
    logic [15:0]         r_len;
    logic [15:0]         r_cnt;
    logic [GRD_W-1:0]    r_gcnt;
    logic [SAMPLE_W-1:0] w_rom_re;
    logic [SAMPLE_W-1:0] w_rom_im;
    logic                w_start;
    logic                w_pre_last;
    logic                w_take;
    logic                w_pl_last;
    logic                w_grd_end;

    packet_preamble_rom #(.PERIOD(PERIOD)) u_rom (
        .i_idx (r_idx),
        .o_re  (w_rom_re),
        .o_im  (w_rom_im)
    );

    assign w_start    = (r_state == ST_IDLE) && start_i;
    assign w_pre_last = (r_idx == IDX_LAST) && (r_rep == REP_LAST);
    assign w_take     = pl_valid_i && pl_ready_o;
    assign w_pl_last  = w_take && (r_cnt == r_len - 16'd1);
    assign w_grd_end  = (r_gcnt == GRD_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (w_start)    w_next = ST_PREAMBLE;
            ST_PREAMBLE: if (w_pre_last) w_next = (r_len != 16'd0) ? ST_PAYLOAD : ST_GUARD;
            ST_PAYLOAD:  if (w_pl_last)  w_next = ST_GUARD;
            ST_GUARD:    if (w_grd_end)  w_next = ST_IDLE;
            default:                     w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        pl_ready_o = (r_state == ST_PAYLOAD);
        busy_o     = (r_state != ST_IDLE);
    end

    // The guard phase spends one extra cycle at GRD_END so a held start_i
    // always sees one idle output cycle between packets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx      <= '0;
            r_rep      <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_gcnt     <= '0;
            r_o        <= '0;
            i_o        <= '0;
            valid_o    <= 1'b0;
            done_o     <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            r_o     <= '0;
            i_o     <= '0;
            valid_o <= 1'b0;
            done_o  <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_start) begin
                    r_len      <= payload_length_i;
                    underrun_o <= 1'b0;
                    r_cnt      <= '0;
                    r_gcnt     <= '0;
                    r_rep      <= '0;
                    r_idx      <= r_idx + IDX_W'(1);
                    r_o        <= w_rom_re;
                    i_o        <= w_rom_im;
                    valid_o    <= 1'b1;
                end
                ST_PREAMBLE: begin
                    r_idx   <= r_idx + IDX_W'(1);
                    r_o     <= w_rom_re;
                    i_o     <= w_rom_im;
                    valid_o <= 1'b1;
                    if (r_idx == IDX_LAST) r_rep <= w_pre_last ? '0 : r_rep + 8'd1;
                end
                ST_PAYLOAD: begin
                    if (w_take) begin
                        r_cnt   <= r_cnt + 16'd1;
                        r_o     <= pl_r_i;
                        i_o     <= pl_i_i;
                        valid_o <= 1'b1;
                    end else begin
                        underrun_o <= 1'b1;
                    end
                end
                ST_GUARD: begin
                    if (w_grd_end) begin
                        r_gcnt <= '0;
                    end else begin
                        r_gcnt  <= r_gcnt + GRD_W'(1);
                        valid_o <= 1'b1;
                        done_o  <= (r_gcnt == GRD_LAST);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_tx_framer.sv
// Randomized bench for packet_tx_framer: a queue model of the expected sample
// stream per packet, with payload stalls and start/reset corner cases.
module tb_packet_tx_framer;
    import packet_tx_framer_pkg::*;

    localparam int unsigned PERIOD    = 16;
    localparam int unsigned REPS      = 10;
    localparam int unsigned GUARD_LEN = 32;
    localparam int unsigned NPRE      = PERIOD * REPS;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [15:0] payload_length_i;
    logic        pl_valid_i;
    logic [15:0] pl_r_i;
    logic [15:0] pl_i_i;
    logic        pl_ready_o;
    logic [15:0] r_o;
    logic [15:0] i_o;
    logic        valid_o;
    logic        busy_o;
    logic        done_o;
    logic        underrun_o;

    always #5 clk = ~clk;

    packet_tx_framer #(.PERIOD(PERIOD), .REPS(REPS), .GUARD_LEN(GUARD_LEN)) dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .payload_length_i (payload_length_i),
        .pl_valid_i       (pl_valid_i),
        .pl_r_i           (pl_r_i),
        .pl_i_i           (pl_i_i),
        .pl_ready_o       (pl_ready_o),
        .r_o              (r_o),
        .i_o              (i_o),
        .valid_o          (valid_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .underrun_o       (underrun_o)
    );

    // Expected preamble symbol, {re, im}
    logic [31:0] pre_tab [16] = '{
        32'h0800_0000, 32'h05A8_05A8, 32'h0000_0800, 32'hFA58_05A8,
        32'hF800_0000, 32'hFA58_FA58, 32'h0000_F800, 32'h05A8_FA58,
        32'h0400_0400, 32'hFC00_0400, 32'h0400_FC00, 32'hFC00_FC00,
        32'h0200_0600, 32'hFE00_FA00, 32'h0600_0200, 32'hFA00_FE00
    };

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [31:0] exp_q [$];
    logic [31:0] pl_data [$];
    bit          pkt_active, exp_underrun, prev_stall;
    int unsigned pops, acc, len_m, src_idx, src_prob, stall_at, stall_left;

    task automatic model_clear();
        exp_q.delete();
        pkt_active   = 0;
        exp_underrun = 0;
        prev_stall   = 0;
        pops = 0; acc = 0; len_m = 0; src_idx = 0;
    endtask

    // One clock: check outputs at negedge, advance model, then drive source at posedge+1.
    task automatic cycle();
        bit accept, phase, stall, take, done_exp;
        logic [31:0] e;
        @(negedge clk);
        chk("busy", busy_o, pkt_active);
        chk("underrun", underrun_o, exp_underrun);
        if (pkt_active) chk("valid", valid_o, !prev_stall);
        else            chk("valid_idle", valid_o, 0);
        done_exp = 0;
        if (valid_o) begin
            if (exp_q.size() == 0) chk("extra_sample", valid_o, 0);
            else begin
                e = exp_q.pop_front();
                chk("r_o", r_o, e[31:16]);
                chk("i_o", i_o, e[15:0]);
                pops++;
                done_exp = (exp_q.size() == 0);
            end
        end
        chk("done", done_o, done_exp);
        phase = pkt_active && pops >= NPRE && acc < len_m;
        chk("pl_ready", pl_ready_o, phase);
        stall  = phase && !pl_valid_i;
        take   = phase && pl_valid_i;
        accept = start_i && !pkt_active;
        if (take) begin acc++; src_idx++; end
        if (stall && stall_left > 0) stall_left--;
        if (stall) exp_underrun = 1;
        prev_stall = stall;
        if (done_exp) pkt_active = 0;
        if (accept) begin
            len_m = payload_length_i;
            exp_q.delete();
            for (int n = 0; n < NPRE; n++) exp_q.push_back(pre_tab[n % PERIOD]);
            for (int k = 0; k < len_m; k++) exp_q.push_back(pl_data[k]);
            for (int g = 0; g < GUARD_LEN; g++) exp_q.push_back(32'h0);
            pkt_active = 1; exp_underrun = 0; prev_stall = 0;
            pops = 0; acc = 0; src_idx = 0;
        end
        @(posedge clk);
        #1;
        if (src_idx == stall_at && stall_left > 0) pl_valid_i = 1'b0;
        else pl_valid_i = ($urandom_range(99) < src_prob);
        if (src_idx < pl_data.size()) {pl_r_i, pl_i_i} = pl_data[src_idx];
        else {pl_r_i, pl_i_i} = $urandom;
    endtask

    task automatic setup_payload(input int unsigned len, input int unsigned prob,
                                 input int unsigned s_at, input int unsigned s_len);
        pl_data.delete();
        for (int k = 0; k < len; k++) pl_data.push_back($urandom);
        payload_length_i = 16'(len);
        src_prob   = prob;
        stall_at   = s_at;
        stall_left = s_len;
    endtask

    // Pulse start, then run until the model sees done; optional stray start pulse at sample 50.
    task automatic run_packet(input bit stray_pulse, input bit hold_start);
        int unsigned budget;
        start_i = 1'b1;
        cycle();
        start_i = hold_start;
        budget = 0;
        while (pkt_active && budget < 3000) begin
            start_i = hold_start || (stray_pulse && pops == 50);
            cycle();
            budget++;
        end
        chk("packet_timeout", exp_q.size(), 0);
        chk("packet_len", pops, NPRE + len_m + GUARD_LEN);
        start_i = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start_i = 1'b0; payload_length_i = '0;
        pl_valid_i = 1'b0; pl_r_i = '0; pl_i_i = '0;
        src_prob = 100; stall_at = 0; stall_left = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_r", r_o, 0);      chk("rst_i", i_o, 0);
        chk("rst_valid", valid_o, 0); chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);   chk("rst_underrun", underrun_o, 0);
        chk("rst_ready", pl_ready_o, 0);
        rst = 1'b0;
        repeat (2) cycle();

        // len=5, source always valid
        setup_payload(5, 100, 0, 0);
        run_packet(0, 0);
        cycle();

        // len=0: preamble straight to guard
        setup_payload(0, 100, 0, 0);
        run_packet(0, 0);
        cycle();

        // len=4 with a 3-cycle stall after two samples; fixed real parts
        setup_payload(4, 100, 2, 3);
        pl_data[0][31:16] = 16'h1000; pl_data[1][31:16] = 16'hF000;
        pl_data[2][31:16] = 16'h0800; pl_data[3][31:16] = 16'h0001;
        run_packet(0, 0);
        repeat (3) cycle();

        // stray start at preamble sample 50, then start held for back-to-back
        setup_payload(3, 100, 0, 0);
        run_packet(1, 1);
        setup_payload(2, 100, 0, 0);
        run_packet(0, 0);
        cycle();

        // random lengths and source duty cycles
        for (int p = 0; p < 6; p++) begin
            setup_payload($urandom_range(24), $urandom_range(40, 100), 0, 0);
            run_packet(0, $urandom_range(1));
            repeat ($urandom_range(2)) cycle();
        end

        // reset while payload sample 2 is being taken
        setup_payload(6, 100, 0, 0);
        start_i = 1'b1;
        cycle();
        start_i = 1'b0;
        for (int b = 0; b < 400 && acc < 2; b++) cycle();
        chk("reach_payload", acc, 2);
        rst = 1'b1;
        #1;
        chk("abort_r", r_o, 0);        chk("abort_i", i_o, 0);
        chk("abort_valid", valid_o, 0); chk("abort_busy", busy_o, 0);
        chk("abort_done", done_o, 0);   chk("abort_ready", pl_ready_o, 0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        setup_payload(7, 80, 0, 0);
        run_packet(0, 0);
        repeat (2) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
